csr_unit: RTL

Parametrised machine-mode CSR file for the in-order RISC-V core. It replaces the fixed CSR block with an asynchronous reset, a configurable number of live hardware performance counters with event selection, `mcountinhibit`, `mtval`, vectored `mtvec`, hardware-sampled interrupt lines and a priority-encoded interrupt request. Decode reads it combinationally, writeback writes it and reports traps and retirements, and fetch takes the trap and mret vectors from it.

---
 rtl/csr_unit.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR file: trap/mret state, vectored mtvec, counters with event select,
// sampled interrupt lines and a fixed-priority interrupt request.
module csr_unit #(
  parameter int unsigned NUM_HPM    = 4,
  parameter int unsigned CNT_W      = 64,
  parameter int unsigned NUM_EVENTS = 8,
  parameter bit          VECTORED   = 1'b1,
  parameter logic [31:0] HART_ID    = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [11:0]           read_address,
  output logic [31:0]           read_data,
  output logic                  readable,
  output logic                  writeable,
  input  logic                  write_enable,
  input  logic [11:0]           write_address,
  input  logic [31:0]           write_data,
  input  logic                  retired,
  input  logic                  traped,
  input  logic                  mret,
  input  logic [31:0]           ecp,
  input  logic [3:0]            trap_cause,
  input  logic                  interupt,
  input  logic [31:0]           trap_value,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  ext_irq,
  input  logic                  timer_irq,
  input  logic                  sw_irq,
  output logic                  irq_pending,
  output logic [3:0]            irq_cause,
  output logic [31:0]           trap_vector,
  output logic [31:0]           mret_vector
);
  localparam int unsigned HpmN    = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam int unsigned HiW     = CNT_W - 32;
  localparam logic [31:0] InhMask = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

  logic             mie_q, mie_d, mpie_q, mpie_d;
  logic [2:0]       ie_q, ie_d, ip_q, ip_d;  // {external, timer, software}
  logic [29:0]      tvec_base_q, tvec_base_d;
  logic             tvec_mode_q, tvec_mode_d;
  logic [31:0]      mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [31:0]      mcause_q, mcause_d, mtval_q, mtval_d, inhibit_q, inhibit_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d;
  logic [CNT_W-1:0] hpm_q [HpmN];
  logic [CNT_W-1:0] hpm_d [HpmN];
  logic [4:0]       evt_q [HpmN];
  logic [4:0]       evt_d [HpmN];
  logic [31:0]      ev_ext;
  logic [2:0]       pend;
  logic             hpm_hi;
  logic [1:0]       unused_ecp;

  assign unused_ecp = ecp[1:0];
  // Bit 31 is always 0 (NUM_EVENTS <= 31), so event id 0 maps onto it and never counts.
  assign ev_ext     = 32'(events);

  always_comb begin
    mie_d       = mie_q;
    mpie_d      = mpie_q;
    ie_d        = ie_q;
    ip_d        = {ext_irq, timer_irq, sw_irq};
    tvec_base_d = tvec_base_q;
    tvec_mode_d = tvec_mode_q;
    mscratch_d  = mscratch_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    inhibit_d   = inhibit_q;
    cycle_d     = cycle_q + CNT_W'(!inhibit_q[0]);
    instret_d   = instret_q + CNT_W'(retired && !inhibit_q[2]);
    for (int i = 0; i < HpmN; i++) begin
      hpm_d[i] = hpm_q[i];
      evt_d[i] = evt_q[i];
    end
    for (int i = 0; i < NUM_HPM; i++) begin
      hpm_d[i] = hpm_q[i] +
                 CNT_W'(ev_ext[evt_q[i] - 5'd1] && (evt_q[i] != 5'd0) && !inhibit_q[3+i]);
    end
    if (write_enable) begin
      case (write_address)
        12'h300: begin
          mie_d  = write_data[3];
          mpie_d = write_data[7];
        end
        12'h304: ie_d = {write_data[11], write_data[7], write_data[3]};
        12'h305: begin
          tvec_base_d = write_data[31:2];
          tvec_mode_d = VECTORED && (write_data[1:0] == 2'b01);
        end
        12'h320: inhibit_d  = write_data & InhMask;
        12'h340: mscratch_d = write_data;
        12'h341: mepc_d     = {write_data[31:2], 2'b00};
        12'h342: mcause_d   = write_data;
        12'h343: mtval_d    = write_data;
        12'hB00: cycle_d    = {cycle_q[CNT_W-1:32], write_data};
        12'hB80: cycle_d    = {write_data[HiW-1:0], cycle_q[31:0]};
        12'hB02: instret_d  = {instret_q[CNT_W-1:32], write_data};
        12'hB82: instret_d  = {write_data[HiW-1:0], instret_q[31:0]};
        default: ;
      endcase
      for (int i = 0; i < NUM_HPM; i++) begin
        if (write_address == 12'hB03 + 12'(i)) hpm_d[i] = {hpm_q[i][CNT_W-1:32], write_data};
        if (write_address == 12'hB83 + 12'(i)) hpm_d[i] = {write_data[HiW-1:0], hpm_q[i][31:0]};
        if (write_address == 12'h323 + 12'(i)) evt_d[i] = write_data[4:0];
      end
    end
    // Trap and mret take precedence over a same-cycle CSR write.
    if (traped) begin
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mepc_d   = {ecp[31:2], 2'b00};
      mcause_d = {interupt, 27'b0, trap_cause};
      mtval_d  = trap_value;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      ie_q        <= '0;
      ip_q        <= '0;
      tvec_base_q <= '0;
      tvec_mode_q <= 1'b0;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      inhibit_q   <= '0;
      cycle_q     <= '0;
      instret_q   <= '0;
      for (int i = 0; i < HpmN; i++) begin
        hpm_q[i] <= '0;
        evt_q[i] <= '0;
      end
    end else begin
      mie_q       <= mie_d;
      mpie_q      <= mpie_d;
      ie_q        <= ie_d;
      ip_q        <= ip_d;
      tvec_base_q <= tvec_base_d;
      tvec_mode_q <= tvec_mode_d;
      mscratch_q  <= mscratch_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      inhibit_q   <= inhibit_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      for (int i = 0; i < HpmN; i++) begin
        hpm_q[i] <= hpm_d[i];
        evt_q[i] <= evt_d[i];
      end
    end
  end

  assign hpm_hi = read_address[7];

  always_comb begin
    read_data = '0;
    readable  = 1'b0;
    writeable = 1'b0;
    case (read_address)
      12'h300: begin
        read_data[3] = mie_q;
        read_data[7] = mpie_q;
        readable     = 1'b1;
        writeable    = 1'b1;
      end
      12'h301: begin read_data = 32'h4000_0100; readable = 1'b1; writeable = 1'b1; end
      12'h304: begin
        read_data[11] = ie_q[2];
        read_data[7]  = ie_q[1];
        read_data[3]  = ie_q[0];
        readable      = 1'b1;
        writeable     = 1'b1;
      end
      12'h305: begin read_data = {tvec_base_q, 1'b0, tvec_mode_q}; readable = 1'b1; writeable = 1'b1; end
      12'h320: begin read_data = inhibit_q;  readable = 1'b1; writeable = 1'b1; end
      12'h340: begin read_data = mscratch_q; readable = 1'b1; writeable = 1'b1; end
      12'h341: begin read_data = mepc_q;     readable = 1'b1; writeable = 1'b1; end
      12'h342: begin read_data = mcause_q;   readable = 1'b1; writeable = 1'b1; end
      12'h343: begin read_data = mtval_q;    readable = 1'b1; writeable = 1'b1; end
      12'h344: begin
        read_data[11] = ip_q[2];
        read_data[7]  = ip_q[1];
        read_data[3]  = ip_q[0];
        readable      = 1'b1;
        writeable     = 1'b1;
      end
      12'hB00, 12'hC00: read_data = cycle_q[31:0];
      12'hB80, 12'hC80: read_data = 32'(cycle_q >> 32);
      12'hB02, 12'hC02: read_data = instret_q[31:0];
      12'hB82, 12'hC82: read_data = 32'(instret_q >> 32);
      12'hF11, 12'hF12, 12'hF13: readable = 1'b1;
      12'hF14: begin read_data = HART_ID; readable = 1'b1; end
      default: ;
    endcase
    if (read_address[11:8] inside {4'hB, 4'hC} && read_address[6:0] inside {7'h00, 7'h02}) begin
      readable  = 1'b1;
      writeable = (read_address[11:8] == 4'hB);
    end
    // hpm counter windows 0xB03..0xB1F / 0xB83..0xB9F and their 0xCxx shadows.
    if (read_address[11:8] inside {4'hB, 4'hC} && read_address[6:5] == 2'b00 &&
        read_address[4:0] >= 5'd3) begin
      readable  = 1'b1;
      writeable = (read_address[11:8] == 4'hB);
      for (int i = 0; i < NUM_HPM; i++) begin
        if (read_address[4:0] == 5'(i + 3)) begin
          read_data = hpm_hi ? 32'(hpm_q[i] >> 32) : hpm_q[i][31:0];
        end
      end
    end
    if (read_address[11:5] == 7'b0011001 && read_address[4:0] >= 5'd3) begin
      readable  = 1'b1;
      writeable = 1'b1;
      for (int i = 0; i < NUM_HPM; i++) begin
        if (read_address[4:0] == 5'(i + 3)) read_data = 32'(evt_q[i]);
      end
    end
  end

  assign pend        = {3{mie_q}} & ie_q & ip_q;
  assign irq_pending = |pend;
  assign irq_cause   = pend[2] ? 4'd11 : pend[0] ? 4'd3 : pend[1] ? 4'd7 : 4'd0;
  assign trap_vector = {tvec_base_q, 2'b00} +
                       ((tvec_mode_q && interupt) ? {26'b0, trap_cause, 2'b00} : 32'b0);
  assign mret_vector = mepc_q;

endmodule
